// File: rtl/sync_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_ram_pkg
// Description : Shared constants and types for the sync_ram block. Holds the
//               default word and address widths plus the matching word type.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_ram_pkg;

    // Default geometry: 4 words x 8 bits.
    localparam int unsigned c_DATA_W = 8;
    localparam int unsigned c_ADDR_W = 2;

    typedef logic [c_DATA_W-1:0] word_t;

endpackage : sync_ram_pkg
`default_nettype wire

// File: rtl/sync_ram_array.sv
`default_nettype none
// ============================================================================
// Module      : sync_ram_array
// Description : Reset-clearable register-file storage. One synchronous write
//               port and one combinational read port sharing an address.
// Ports       : clk     - clock, writes on rising edge
//               rst_n   - asynchronous active-low reset, clears every word
//               i_we    - write enable
//               i_addr  - word address for both read and write
//               i_din   - write data
//               o_rdata - combinational read data, contents of word i_addr
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ram_array
    import sync_ram_pkg::*;
#(
    parameter int unsigned DATA_W = c_DATA_W,
    parameter int unsigned ADDR_W = c_ADDR_W,
    parameter int unsigned DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_rdata
);

    // Every address value must map to a real word; no decode for holes.
    if (DEPTH != 2**ADDR_W) begin : g_depth_check
        $error("sync_ram_array: DEPTH must equal 2**ADDR_W");
    end

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Flip-flop storage rather than an inferred RAM macro, so the async
    // reset can clear all words at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_addr] <= i_din;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule : sync_ram_array
`default_nettype wire

// File: rtl/sync_ram.sv
`default_nettype none
// ============================================================================
// Module      : sync_ram
// Description : Single-port synchronous RAM with registered read data.
//               Read-first on a same-address read-during-write.
// Ports       : clk   - clock, all state changes on rising edge
//               rst_n - asynchronous active-low reset, clears storage and dout
//               we    - write enable (1 = write din to mem[addr])
//               addr  - word address shared by read and write
//               din   - write data
//               dout  - registered read data, mem[addr] one edge after addr
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ram
    import sync_ram_pkg::*;
#(
    parameter int unsigned DATA_W = c_DATA_W,
    parameter int unsigned ADDR_W = c_ADDR_W,
    parameter int unsigned DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic              w_wr_en;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] r_dout;

    // Reset gating of writes is handled by the storage's async reset
    // priority; a write edge seen while rst_n is low never lands.
    assign w_wr_en = we;

    sync_ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_wr_en),
        .i_addr  (addr),
        .i_din   (din),
        .o_rdata (w_rdata)
    );

    // w_rdata reflects the storage before this edge's write commits, so
    // capturing it here gives read-first behaviour for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= '0;
        end else begin
            r_dout <= w_rdata;
        end
    end

    assign dout = r_dout;

endmodule : sync_ram
`default_nettype wire

// File: tb/tb_sync_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_ram
// Description : Self-checking bench for sync_ram. A table of directed
//               {we, addr, din, expected dout} vectors is applied one per
//               cycle, followed by hand-written reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_ram;
    import sync_ram_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [1:0]  addr;
    word_t       din;
    word_t       dout;

    int checks;
    int errors;

    typedef struct {
        logic       we;
        logic [1:0] addr;
        logic [7:0] din;
        logic [7:0] exp;   // dout expected just after the edge
    } vec_t;

    vec_t vecs [$];

    sync_ram dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .addr  (addr),
        .din   (din),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guards against any unexpected stall of the stimulus.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic w, input logic [1:0] a, input logic [7:0] d, input logic [7:0] e);
        vec_t v;
        v.we = w; v.addr = a; v.din = d; v.exp = e;
        vecs.push_back(v);
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic cycle(input logic w, input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        we = w; addr = a; din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        we     = 1'b0;
        addr   = 2'd0;
        din    = 8'h00;

        // ---------------- reset state
        @(posedge clk); #1;
        check("reset_dout", dout, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table: basic, read-during-write, no-disturb, hold
        add(1, 2'd0, 8'hAA, 8'h00);
        add(1, 2'd1, 8'h55, 8'h00);
        add(1, 2'd2, 8'hFF, 8'h00);
        add(0, 2'd0, 8'h00, 8'hAA);
        add(0, 2'd1, 8'h00, 8'h55);
        add(0, 2'd2, 8'h00, 8'hFF);
        add(1, 2'd3, 8'h12, 8'h00);
        add(1, 2'd3, 8'h34, 8'h12);   // read-first: old contents
        add(0, 2'd3, 8'h00, 8'h34);
        add(1, 2'd0, 8'h01, 8'hAA);
        add(1, 2'd1, 8'h02, 8'h55);
        add(1, 2'd2, 8'h03, 8'hFF);
        add(1, 2'd3, 8'h04, 8'h34);
        add(1, 2'd1, 8'hC3, 8'h02);
        add(0, 2'd0, 8'h00, 8'h01);
        add(0, 2'd1, 8'h00, 8'hC3);
        add(0, 2'd2, 8'h00, 8'h03);
        add(0, 2'd3, 8'h00, 8'h04);
        add(1, 2'd1, 8'h55, 8'hC3);
        for (int i = 0; i < 10; i++) add(0, 2'd1, 8'h00, 8'h55);

        foreach (vecs[i]) begin
            cycle(vecs[i].we, vecs[i].addr, vecs[i].din);
            check($sformatf("vec%0d", i), dout, vecs[i].exp);
        end

        // ---------------- reset clears storage and dout immediately
        for (int i = 0; i < 4; i++) cycle(1, i[1:0], 8'hFF);
        cycle(0, 2'd2, 8'h00);
        check("prefill_read", dout, 8'hFF);
        @(negedge clk);
        we = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_reset_dout", dout, 8'h00);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(0, i[1:0], 8'h00);
            check($sformatf("post_reset_rd%0d", i), dout, 8'h00);
        end

        // ---------------- reset held across a write edge
        cycle(1, 2'd2, 8'h11);
        cycle(0, 2'd2, 8'h00);
        check("pre_rst_write", dout, 8'h11);
        @(negedge clk);
        rst_n = 1'b0;
        we = 1'b1; addr = 2'd2; din = 8'h77;
        @(posedge clk); #1;
        check("rst_write_dout", dout, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        we = 1'b0; addr = 2'd2; din = 8'h00;
        @(posedge clk); #1;
        check("rst_write_discard", dout, 8'h00);
        // First edge after release is a normal operating edge.
        cycle(1, 2'd0, 8'h5A);
        cycle(0, 2'd0, 8'h00);
        check("post_release_write", dout, 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sync_ram
`default_nettype wire
